// File: rtl/vga_pkg.sv
// Shared constants, owner encodings and colour expansion for the VGA VRAM arbiter.
package vga_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_RD   = 2'd1,
        OWN_WR   = 2'd2
    } owner_e;

    // Each 4-bit channel n becomes the byte {n,n} so full scale maps to 8'hFF.
    function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
        return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
    endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO queuing host writes until the display leaves the RAM idle.
module vga_wr_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port VRAM between VGA scan-out (always first) and queued host writes.
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         pclk,
    input  logic                         reset,
    input  logic                         vga_valid,
    input  logic [9:0]                   h_addr,
    input  logic [9:0]                   v_addr,
    output logic [23:0]                  vga_data,
    input  logic                         host_wr_valid,
    output logic                         host_wr_ready,
    input  logic [ADDR_W-1:0]            host_wr_addr,
    input  logic [DATA_W-1:0]            host_wr_data,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_we,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [1:0]                   owner,
    output logic                         err_oob
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W + 1)'(H_RES * V_RES);

    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ADDR_W-1:0]  rd_addr;
    owner_e             grant;
    logic               oob_hit;

    logic   rd_q, rd_d;
    owner_e owner_q, owner_d;
    logic   err_oob_q, err_oob_d;

    vga_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (pclk),
        .reset (reset),
        .push  (host_wr_valid),
        .pop   (fifo_pop),
        .wdata ({host_wr_addr, host_wr_data}),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_addr, head_data} = fifo_head;
    assign host_wr_ready = !fifo_full;
    assign rd_addr = ADDR_W'(v_addr) * ADDR_W'(H_RES) + ADDR_W'(h_addr);

    // Grant and RAM port drive: scan-out wins, then the queue head, else idle.
    always_comb begin
        grant     = OWN_IDLE;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        fifo_pop  = 1'b0;
        oob_hit   = 1'b0;
        if (vga_valid) begin
            grant    = OWN_RD;
            mem_addr = rd_addr;
        end else if (!fifo_empty) begin
            grant     = OWN_WR;
            fifo_pop  = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
            if ({1'b0, head_addr} < PIX_LIMIT) begin
                mem_we = !reset;
            end else begin
                oob_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_d      = (grant == OWN_RD);
        owner_d   = grant;
        err_oob_d = err_oob_q | oob_hit;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            rd_q      <= 1'b0;
            owner_q   <= OWN_IDLE;
            err_oob_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            owner_q   <= owner_d;
            err_oob_q <= err_oob_d;
        end
    end

    // RAM data arrives one cycle after the read address, aligned with rd_q.
    assign vga_data = rd_q ? rgb444_to_888(mem_rdata) : 24'h0;
    assign owner    = owner_q;
    assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed table-driven bench for vga_vram_arbiter with hand-written FIFO/reset sequences.
module tb_vga_vram_arbiter;

    logic        pclk;
    logic        reset;
    logic        vga_valid;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [23:0] vga_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [18:0] host_wr_addr;
    logic [11:0] host_wr_data;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [2:0]  fifo_level;
    logic [1:0]  owner;
    logic        err_oob;

    int checks = 0;
    int errors = 0;

    vga_vram_arbiter dut (
        .pclk          (pclk),
        .reset         (reset),
        .vga_valid     (vga_valid),
        .h_addr        (h_addr),
        .v_addr        (v_addr),
        .vga_data      (vga_data),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .fifo_level    (fifo_level),
        .owner         (owner),
        .err_oob       (err_oob)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        vv;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [11:0] rd;
        logic [18:0] ea;
        logic [23:0] ed;
        logic [1:0]  eo;
    } rvec_t;

    rvec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_wr(input string nm, input logic [18:0] a, input logic [11:0] d);
        chk({nm, "_we"}, 32'(mem_we), 32'd1);
        chk({nm, "_addr"}, 32'(mem_addr), 32'(a));
        chk({nm, "_wdata"}, 32'(mem_wdata), 32'(d));
    endtask

    initial begin
        // Read-path vectors: rd is the RAM response to the previous row's address.
        tbl[0] = '{1'b1, 10'd3,   10'd2,   12'h000, 19'd1283,   24'h000000, 2'd0};
        tbl[1] = '{1'b1, 10'd0,   10'd0,   12'hF0A, 19'd0,      24'hFF00AA, 2'd1};
        tbl[2] = '{1'b1, 10'd639, 10'd479, 12'h123, 19'd307199, 24'h112233, 2'd1};
        tbl[3] = '{1'b0, 10'd5,   10'd5,   12'hFFF, 19'd0,      24'hFFFFFF, 2'd1};
        tbl[4] = '{1'b0, 10'd0,   10'd0,   12'h0AB, 19'd0,      24'h000000, 2'd0};
        tbl[5] = '{1'b1, 10'd1,   10'd1,   12'h000, 19'd641,    24'h000000, 2'd0};
        tbl[6] = '{1'b1, 10'd10,  10'd100, 12'h5C3, 19'd64010,  24'h55CC33, 2'd1};
        tbl[7] = '{1'b0, 10'd0,   10'd0,   12'h000, 19'd0,      24'h000000, 2'd1};

        reset         = 1'b1;
        vga_valid     = 1'b0;
        h_addr        = '0;
        v_addr        = '0;
        host_wr_valid = 1'b1;
        host_wr_addr  = 19'd7;
        host_wr_data  = 12'h111;
        mem_rdata     = 12'h000;

        // Reset held two cycles with a host write pending.
        for (int c = 0; c < 2; c++) begin
            step();
            settle();
            chk("rst_vga_data", 32'(vga_data), 32'h0);
            chk("rst_level", 32'(fifo_level), 32'd0);
            chk("rst_err_oob", 32'(err_oob), 32'd0);
            chk("rst_ready", 32'(host_wr_ready), 32'd1);
            chk("rst_we", 32'(mem_we), 32'd0);
            chk("rst_owner", 32'(owner), 32'd0);
        end

        reset         = 1'b0;
        host_wr_valid = 1'b0;

        // Table-driven read path.
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step();
            vga_valid = tbl[i].vv;
            h_addr    = tbl[i].h;
            v_addr    = tbl[i].v;
            mem_rdata = tbl[i].rd;
            settle();
            chk($sformatf("rd%0d_addr", i), 32'(mem_addr), 32'(tbl[i].ea));
            chk($sformatf("rd%0d_we", i), 32'(mem_we), 32'd0);
            chk($sformatf("rd%0d_data", i), 32'(vga_data), 32'(tbl[i].ed));
            chk($sformatf("rd%0d_owner", i), 32'(owner), 32'(tbl[i].eo));
        end

        // Single write during blanking retires the following cycle.
        step();
        host_wr_valid = 1'b1;
        host_wr_addr  = 19'd100;
        host_wr_data  = 12'h123;
        settle();
        chk("w1_ready", 32'(host_wr_ready), 32'd1);
        chk("w1_we_before", 32'(mem_we), 32'd0);
        step();
        host_wr_valid = 1'b0;
        settle();
        chk_wr("w1", 19'd100, 12'h123);
        chk("w1_level", 32'(fifo_level), 32'd1);
        step();
        settle();
        chk("w1_level_after", 32'(fifo_level), 32'd0);
        chk("w1_we_after", 32'(mem_we), 32'd0);
        chk("w1_owner", 32'(owner), 32'd2);

        // Fill the queue while scan-out owns the RAM.
        vga_valid = 1'b1;
        h_addr    = 10'd0;
        v_addr    = 10'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            host_wr_valid = 1'b1;
            host_wr_addr  = 19'(10 + k);
            host_wr_data  = 12'(12'hA00 + k);
            settle();
            chk($sformatf("fill%0d_we", k), 32'(mem_we), 32'd0);
        end
        step();
        host_wr_addr = 19'd99;
        host_wr_data = 12'h999;
        settle();
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(host_wr_ready), 32'd0);
        step();
        settle();
        chk("stall_level", 32'(fifo_level), 32'd4);
        chk("stall_ready", 32'(host_wr_ready), 32'd0);
        chk("stall_we", 32'(mem_we), 32'd0);

        // Blanking: drain in order; the stalled write enters once ready returns.
        vga_valid = 1'b0;
        settle();
        chk_wr("drain0", 19'd10, 12'hA00);
        chk("drain0_ready", 32'(host_wr_ready), 32'd0);
        step();
        settle();
        chk_wr("drain1", 19'd11, 12'hA01);
        chk("drain1_level", 32'(fifo_level), 32'd3);
        chk("drain1_ready", 32'(host_wr_ready), 32'd1);
        step();
        host_wr_valid = 1'b0;
        settle();
        chk_wr("drain2", 19'd12, 12'hA02);
        chk("drain2_level", 32'(fifo_level), 32'd3);
        step();
        settle();
        chk_wr("drain3", 19'd13, 12'hA03);
        step();
        settle();
        chk_wr("drain4", 19'd99, 12'h999);
        chk("drain4_level", 32'(fifo_level), 32'd1);
        step();
        settle();
        chk("drained_level", 32'(fifo_level), 32'd0);
        chk("drained_we", 32'(mem_we), 32'd0);

        // Out-of-range write is dropped and flagged; next valid write commits.
        step();
        host_wr_valid = 1'b1;
        host_wr_addr  = 19'd307200;
        host_wr_data  = 12'hFFF;
        settle();
        step();
        host_wr_addr = 19'd5;
        host_wr_data = 12'h456;
        settle();
        chk("oob_we", 32'(mem_we), 32'd0);
        chk("oob_addr", 32'(mem_addr), 32'd307200);
        chk("oob_flag_pre", 32'(err_oob), 32'd0);
        step();
        host_wr_valid = 1'b0;
        settle();
        chk("oob_flag", 32'(err_oob), 32'd1);
        chk("oob_level", 32'(fifo_level), 32'd1);
        chk_wr("oob_next", 19'd5, 12'h456);
        for (int k = 0; k < 2; k++) begin
            step();
            settle();
            chk($sformatf("oob_hold%0d", k), 32'(err_oob), 32'd1);
        end

        // Reset in the middle of a drain.
        vga_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            host_wr_valid = 1'b1;
            host_wr_addr  = 19'(200 + k);
            host_wr_data  = 12'(12'h300 + k);
        end
        step();
        host_wr_valid = 1'b0;
        vga_valid     = 1'b0;
        settle();
        chk("mid_level", 32'(fifo_level), 32'd3);
        chk_wr("mid0", 19'd200, 12'h300);
        step();
        reset     = 1'b1;
        vga_valid = 1'b1;
        mem_rdata = 12'hFFF;
        settle();
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        step();
        reset     = 1'b0;
        vga_valid = 1'b0;
        settle();
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_vga_data", 32'(vga_data), 32'h0);
        chk("post_rst_err_oob", 32'(err_oob), 32'd0);
        chk("post_rst_ready", 32'(host_wr_ready), 32'd1);
        chk("post_rst_owner", 32'(owner), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_rst_we%0d", k), 32'(mem_we), 32'd0);
            step();
            settle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port video RAM between two users: the VGA scan-out path, which reads one pixel per active pclk cycle, and a host writer that updates the frame buffer.
- Scan-out always has priority. Host writes are queued in a small FIFO and retired only on cycles where the display is not reading (h/v blanking).
- Sits between the VGA timing controller (consumes its valid, h_addr and v_addr) and the RAM. Returns the 24-bit colour that the timing controller expects as vga_data.

Parameters:
- H_RES, 640, active pixels per line; used in address computation and range checks.
- V_RES, 480, active lines per frame.
- ADDR_W, 19, RAM word-address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- DATA_W, 12, RAM word width in RGB444 packing {r[3:0],g[3:0],b[3:0]}; fixed at 12.
- FIFO_DEPTH, 4, host write queue depth; power of two, >= 2.

Ports:
- pclk  in  1  pixel clock, 25 MHz; sole clock.
- reset  in  1  synchronous, active-high reset.
- vga_valid  in  1  display-active flag from the timing controller.
- h_addr  in  10  current pixel column, meaningful when vga_valid=1.
- v_addr  in  10  current pixel row, meaningful when vga_valid=1.
- vga_data  out  24  expanded RGB888 colour to the timing controller.
- host_wr_valid  in  1  host write request.
- host_wr_ready  out  1  FIFO can accept a write.
- host_wr_addr  in  ADDR_W  target word address.
- host_wr_data  in  DATA_W  RGB444 pixel to write.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, data is valid the cycle after the address.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- owner  out  2  registered grant of the previous cycle: IDLE=0, RD=1, WR=2.
- err_oob  out  1  sticky flag: a dropped out-of-range write occurred.

Behaviour:
- Reset (synchronous, while reset=1 at a pclk edge):
  - FIFO emptied, all pending writes discarded.
  - fifo_level=0, host_wr_ready=1 after the edge.
  - owner=IDLE, err_oob=0, read-pending flag rd_q=0, so vga_data=0.
  - mem_we=0 while reset is high.
- Grant is combinational each cycle, in priority order:
  - RD if vga_valid=1.
  - Else WR if the FIFO is non-empty.
  - Else IDLE.
- RD grant:
  - mem_addr = v_addr*H_RES + h_addr, computed at ADDR_W bits with no truncation; mem_we=0.
  - rd_q is registered as 1.
- WR grant:
  - mem_addr and mem_wdata take the FIFO head; the head is popped.
  - mem_we=1 only if head address < H_RES*V_RES.
  - Otherwise mem_we=0, the entry is still popped, and err_oob is set until reset.
- IDLE grant: mem_we=0, mem_addr=0, rd_q registered as 0.
- Read latency is exactly 1 cycle:
  - vga_data = rd_q ? {r,r,g,g,b,b} : 24'h0, where each 4-bit nibble n becomes the byte {n,n}.
  - The upper level delays hsync, vsync and valid by 1 pclk to align with this.
- Host handshake:
  - Transfer occurs when host_wr_valid && host_wr_ready.
  - host_wr_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - The host must hold addr/data stable while valid && !ready.
- FIFO boundaries:
  - No bypass. A write pushed in cycle t can be retired no earlier than cycle t+1.
  - Push and pop in the same cycle leave the level unchanged. Data ordering is preserved (first in, first out).
  - When full, ready=0, so no push occurs even if a pop happens that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Starvation: none is guaranteed against. Queued writes wait through the whole active line and retire in blanking (160 cycles per line minimum).
- owner register: holds the previous cycle's grant, for debug and bench use only.

Decomposition:
- Package vga_pkg holds:
  - H_RES and V_RES defaults.
  - Owner encodings OWN_IDLE, OWN_RD, OWN_WR.
  - An rgb444_to_888 function.
- Sub-module vga_wr_fifo:
  - Synchronous FIFO, data width ADDR_W+DATA_W.
  - Provides level, full, empty, push, pop and head outputs.
- The arbiter top holds the grant logic, address computation, rd_q, err_oob and owner.

Test Plan:
- Assert reset for 2 cycles, with host_wr_valid=1 during reset -> vga_data=0, fifo_level=0, err_oob=0, host_wr_ready=1, mem_we=0 throughout reset.
- vga_valid=1, h_addr=3, v_addr=2 -> mem_addr=1283, mem_we=0. With mem_rdata=12'hF0A returned next cycle -> vga_data=24'hFF00AA on that cycle, owner=RD.
- vga_valid=0, push addr=100, data=12'h123 at cycle t -> mem_we=1, mem_addr=100, mem_wdata=12'h123 at t+1; fifo_level returns to 0.
- Hold vga_valid=1 and push 4 writes -> host_wr_ready=0 at level 4 and the 5th write stalls. Drop vga_valid -> four writes retire in push order on consecutive cycles, and ready returns after the first pop.
- Push addr=307200 during blanking -> mem_we stays 0, entry popped, err_oob=1 and held. A subsequent valid write to addr=5 still commits.
- Queue 3 writes, then pulse reset mid-drain -> fifo_level=0 and no further mem_we; rd_q cleared so vga_data=0 on the next cycle.
